// File: rtl/apb_txn_scheduler_if.sv
// apb_txn_scheduler_if
//   Bundles the AXI-side request/response handshakes and the APB bus that the
//   scheduler sits between.
//   master modport : the scheduler (drives req_ready, responses and APB outputs)
//   slave modport  : everything around it (request buffers, response logic,
//                    APB slaves)
//   Request side   : wr_req_*, rd_req_* (valid/ready, address, write data)
//   Response side  : wr_resp_*, rd_resp_* (valid/ready, 2-bit resp, read data)
//   APB side       : pclk, preset_n, psel[7:0], penable, pwrite, paddr, pwdata,
//                    prdata, pready, pslverr
interface apb_txn_scheduler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  wr_req_valid;
   logic                  wr_req_ready;
   logic [ADDR_WIDTH-1:0] wr_req_addr;
   logic [DATA_WIDTH-1:0] wr_req_data;
   logic                  wr_resp_valid;
   logic                  wr_resp_ready;
   logic [1:0]            wr_resp;
   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [ADDR_WIDTH-1:0] rd_req_addr;
   logic                  rd_resp_valid;
   logic                  rd_resp_ready;
   logic [1:0]            rd_resp;
   logic [DATA_WIDTH-1:0] rd_resp_data;
   logic                  pclk;
   logic                  preset_n;
   logic [7:0]            psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      input  wr_req_valid, wr_req_addr, wr_req_data, wr_resp_ready,
      input  rd_req_valid, rd_req_addr, rd_resp_ready,
      input  prdata, pready, pslverr,
      output wr_req_ready, wr_resp_valid, wr_resp,
      output rd_req_ready, rd_resp_valid, rd_resp, rd_resp_data,
      output pclk, preset_n, psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output wr_req_valid, wr_req_addr, wr_req_data, wr_resp_ready,
      output rd_req_valid, rd_req_addr, rd_resp_ready,
      output prdata, pready, pslverr,
      input  wr_req_ready, wr_resp_valid, wr_resp,
      input  rd_req_ready, rd_resp_valid, rd_resp, rd_resp_data,
      input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_txn_scheduler.sv
// apb_txn_scheduler
//   Round-robin arbiter between one pending write and one pending read, each
//   winner run through an APB SETUP/ACCESS transfer with a pready timeout.
//   Responses (00 OKAY / 10 SLVERR) go back per direction, one outstanding
//   response per direction.
//   clk     : single clock, forwarded as pclk
//   reset_n : asynchronous active-low reset, forwarded as preset_n
//   bus     : apb_txn_scheduler_if master modport (request, response, APB);
//             its ADDR_WIDTH/DATA_WIDTH must match this module's parameters.
module apb_txn_scheduler #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   apb_txn_scheduler_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        rd_pref;     // read wins the next tie (last grant was a write)
   logic [15:0] to_cnt;      // ACCESS cycles already spent without pready
   logic        wr_elig, rd_elig, grant_wr, grant_rd, done;
   logic [1:0]  done_resp;

   assign bus.pclk     = clk;
   assign bus.preset_n = reset_n;

   // A direction with an unconsumed response may not start another transfer.
   assign wr_elig  = bus.wr_req_valid & ~bus.wr_resp_valid;
   assign rd_elig  = bus.rd_req_valid & ~bus.rd_resp_valid;
   assign grant_wr = wr_elig & (~rd_elig | ~rd_pref);
   assign grant_rd = rd_elig & ~grant_wr;

   // Without pready the only way to finish is the timeout, which is SLVERR.
   assign done_resp = (bus.pready & ~bus.pslverr) ? 2'b00 : 2'b10;

   assign bus.penable = (state == ACCESS);
   assign bus.psel    = (state == IDLE) ? 8'h00
                                        : (8'h01 << bus.paddr[ADDR_WIDTH-1 -: 3]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE:    if (grant_wr || grant_rd) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (bus.pready || (to_cnt == TO_LAST)) begin
                     done      = 1'b1;
                     state_nxt = IDLE;
                  end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.wr_req_ready  <= 1'b0;
         bus.rd_req_ready  <= 1'b0;
         bus.paddr         <= '0;
         bus.pwdata        <= '0;
         bus.pwrite        <= 1'b0;
         bus.wr_resp_valid <= 1'b0;
         bus.wr_resp       <= 2'b00;
         bus.rd_resp_valid <= 1'b0;
         bus.rd_resp       <= 2'b00;
         bus.rd_resp_data  <= '0;
         rd_pref           <= 1'b0;
         to_cnt            <= '0;
      end else begin
         // Request is sampled at the grant edge; the ready pulse that follows
         // tells the requester it may move on to its next request.
         bus.wr_req_ready <= (state == IDLE) && grant_wr;
         bus.rd_req_ready <= (state == IDLE) && grant_rd;
         if ((state == IDLE) && (grant_wr || grant_rd)) begin
            bus.paddr  <= grant_wr ? bus.wr_req_addr : bus.rd_req_addr;
            bus.pwrite <= grant_wr;
            if (grant_wr) bus.pwdata <= bus.wr_req_data;
            rd_pref <= grant_wr;
         end

         if (state == SETUP)                 to_cnt <= '0;
         else if ((state == ACCESS) && !done) to_cnt <= to_cnt + 16'd1;

         if (done && bus.pwrite) begin
            bus.wr_resp_valid <= 1'b1;
            bus.wr_resp       <= done_resp;
         end else if (bus.wr_resp_ready) begin
            bus.wr_resp_valid <= 1'b0;
         end

         if (done && !bus.pwrite) begin
            bus.rd_resp_valid <= 1'b1;
            bus.rd_resp       <= done_resp;
            bus.rd_resp_data  <= bus.pready ? bus.prdata : '0;
         end else if (bus.rd_resp_ready) begin
            bus.rd_resp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_apb_txn_scheduler.sv
// tb_apb_txn_scheduler
//   Drives apb_txn_scheduler as requester, response consumer and APB slave.
//   A transaction-level model (busy flag + cycles-since-grant counter, one
//   response slot per direction) predicts every output each cycle; directed
//   scenarios add literal expectations on top.
module tb_apb_txn_scheduler;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   apb_txn_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_txn_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // stimulus modes
   int req_mode;   // 0 random, 1 hold after grant, 2 drop after grant
   int wrr_mode;   // 0 random, 1 always ready, 2 never ready
   int rdr_mode;
   int sl_mode;    // 0 random slave, 1 directed (sl_wait wait cycles)
   int sl_wait;
   bit sl_err;
   logic [31:0] sl_data;
   bit hang;

   // reference model
   bit          m_busy;
   int          m_t;        // cycles since grant: 1 = SETUP, >=2 = ACCESS
   bit          m_pwrite, m_last_wr;
   logic [31:0] m_addr, m_wdata;
   bit          m_wv, m_rv;
   logic [1:0]  m_wr, m_rr;
   logic [31:0] m_rd;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_t = 0; m_pwrite = 0; m_last_wr = 0;
      m_addr = '0; m_wdata = '0;
      m_wv = 0; m_rv = 0; m_wr = 2'b00; m_rr = 2'b00; m_rd = '0;
   endtask

   task automatic compare();
      logic [7:0] ep;
      ep = '0;
      if (m_busy) ep[m_addr[31:29]] = 1'b1;
      chk("psel", 64'(bus.psel), 64'(ep));
      chk("penable", 64'(bus.penable), 64'(m_busy && m_t >= 2));
      chk("wr_req_ready", 64'(bus.wr_req_ready), 64'(m_busy && m_t == 1 && m_pwrite));
      chk("rd_req_ready", 64'(bus.rd_req_ready), 64'(m_busy && m_t == 1 && !m_pwrite));
      chk("wr_resp_valid", 64'(bus.wr_resp_valid), 64'(m_wv));
      chk("rd_resp_valid", 64'(bus.rd_resp_valid), 64'(m_rv));
      chk("preset_n", 64'(bus.preset_n), 64'(reset_n));
      if (m_busy) begin
         chk("paddr", 64'(bus.paddr), 64'(m_addr));
         chk("pwrite", 64'(bus.pwrite), 64'(m_pwrite));
         if (m_pwrite) chk("pwdata", 64'(bus.pwdata), 64'(m_wdata));
      end
      if (m_wv) chk("wr_resp", 64'(bus.wr_resp), 64'(m_wr));
      if (m_rv) begin
         chk("rd_resp", 64'(bus.rd_resp), 64'(m_rr));
         chk("rd_resp_data", 64'(bus.rd_resp_data), 64'(m_rd));
      end
   endtask

   task automatic drive();
      if (bus.wr_req_ready && req_mode != 1) bus.wr_req_valid = 1'b0;
      if (bus.rd_req_ready && req_mode != 1) bus.rd_req_valid = 1'b0;
      if (req_mode == 0 && !bus.wr_req_valid && $urandom_range(0, 2) == 0) begin
         bus.wr_req_valid = 1'b1; bus.wr_req_addr = $urandom; bus.wr_req_data = $urandom;
      end
      if (req_mode == 0 && !bus.rd_req_valid && $urandom_range(0, 2) == 0) begin
         bus.rd_req_valid = 1'b1; bus.rd_req_addr = $urandom;
      end
      bus.wr_resp_ready = (wrr_mode == 1) || (wrr_mode == 0 && $urandom_range(0, 1) == 1);
      bus.rd_resp_ready = (rdr_mode == 1) || (rdr_mode == 0 && $urandom_range(0, 1) == 1);
      if (m_busy && m_t == 1) hang = (sl_mode == 0) && ($urandom_range(0, 6) == 0);
      if (m_busy && m_t >= 2)
         bus.pready = (sl_mode == 0) ? (!hang && $urandom_range(0, 2) == 0) : (m_t - 1 > sl_wait);
      else
         bus.pready = 1'($urandom);
      bus.pslverr = (sl_mode == 0) ? 1'($urandom) : sl_err;
      bus.prdata  = (sl_mode == 0) ? $urandom : sl_data;
   endtask

   // Advance the model across the coming clock edge using the inputs just driven.
   task automatic update();
      bit we, re, gw;
      int acc;
      we = bus.wr_req_valid && !m_wv;
      re = bus.rd_req_valid && !m_rv;
      if (m_wv && bus.wr_resp_ready) m_wv = 0;
      if (m_rv && bus.rd_resp_ready) m_rv = 0;
      if (!m_busy) begin
         if (we || re) begin
            gw = we && (!re || !m_last_wr);
            m_busy = 1; m_t = 1; m_pwrite = gw; m_last_wr = gw;
            m_addr = gw ? bus.wr_req_addr : bus.rd_req_addr;
            if (gw) m_wdata = bus.wr_req_data;
         end
      end else if (m_t == 1) begin
         m_t = 2;
      end else begin
         acc = m_t - 1;
         if (bus.pready || acc == TO) begin
            m_busy = 0;
            if (m_pwrite) begin
               m_wv = 1; m_wr = (bus.pready && !bus.pslverr) ? 2'b00 : 2'b10;
            end else begin
               m_rv = 1; m_rr = (bus.pready && !bus.pslverr) ? 2'b00 : 2'b10;
               m_rd = bus.pready ? bus.prdata : 32'h0;
            end
         end else begin
            m_t++;
         end
      end
   endtask

   task automatic cycle();
      drive();
      update();
      @(negedge clk);
      compare();
   endtask

   task automatic clear_inputs();
      bus.wr_req_valid = 0; bus.wr_req_addr = '0; bus.wr_req_data = '0;
      bus.rd_req_valid = 0; bus.rd_req_addr = '0;
      bus.wr_resp_ready = 0; bus.rd_resp_ready = 0;
      bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      req_mode = 2; wrr_mode = 1; rdr_mode = 1;
      sl_mode = 1; sl_wait = 0; sl_err = 0; sl_data = '0; hang = 0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Run until a response shows up; report the APB phases seen on the way.
   task automatic run_xfer(output int setup_n, output int acc_n,
                           output logic [7:0] psel_seen, output logic [31:0] pwdata_seen);
      bit got;
      setup_n = 0; acc_n = 0; psel_seen = '0; pwdata_seen = '0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         cycle();
         if (bus.psel != 0 && !bus.penable) begin
            setup_n++; psel_seen = bus.psel; pwdata_seen = bus.pwdata;
         end
         if (bus.penable) acc_n++;
         if (bus.wr_resp_valid || bus.rd_resp_valid) got = 1;
      end
      chk("xfer_done", 64'(got), 64'd1);
   endtask

   initial begin
      int su, ac, k, wg, rg, ng;
      logic [7:0]  ps, obs;
      logic [31:0] pw;

      // reset values
      reset_n = 1'b0;
      clear_inputs();
      model_reset();
      bus.wr_req_valid = 1'b1; bus.rd_req_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_psel", 64'(bus.psel), 64'h0);
      chk("rst_penable", 64'(bus.penable), 64'h0);
      chk("rst_paddr", 64'(bus.paddr), 64'h0);
      chk("rst_pwdata", 64'(bus.pwdata), 64'h0);
      chk("rst_req_ready", 64'({bus.wr_req_ready, bus.rd_req_ready}), 64'h0);
      chk("rst_resp", 64'({bus.wr_resp_valid, bus.rd_resp_valid, bus.wr_resp, bus.rd_resp}), 64'h0);
      chk("rst_rd_resp_data", 64'(bus.rd_resp_data), 64'h0);
      chk("rst_preset_n", 64'(bus.preset_n), 64'h0);

      // single write
      do_reset();
      bus.wr_req_valid = 1; bus.wr_req_addr = 32'h4000_0010; bus.wr_req_data = 32'hDEAD_BEEF;
      run_xfer(su, ac, ps, pw);
      chk("w_psel", 64'(ps), 64'h04);
      chk("w_pwdata", 64'(pw), 64'hDEAD_BEEF);
      chk("w_setup_cycles", 64'(su), 64'd1);
      chk("w_access_cycles", 64'(ac), 64'd1);
      chk("w_resp", 64'({bus.wr_resp_valid, bus.wr_resp}), 64'b100);
      chk("w_idle_after", 64'({bus.psel, bus.penable}), 64'h0);

      // read with 3 wait states and pslverr
      sl_wait = 3; sl_err = 1; sl_data = 32'h1234_5678;
      bus.rd_req_valid = 1; bus.rd_req_addr = 32'hE000_0004;
      run_xfer(su, ac, ps, pw);
      chk("r_psel", 64'(ps), 64'h80);
      chk("r_access_cycles", 64'(ac), 64'd4);
      chk("r_resp", 64'({bus.rd_resp_valid, bus.rd_resp}), 64'b110);
      chk("r_data", 64'(bus.rd_resp_data), 64'h1234_5678);

      // pready never comes: timeout
      sl_wait = 1000; sl_err = 0; sl_data = 32'hFFFF_FFFF;
      bus.rd_req_valid = 1; bus.rd_req_addr = 32'h2000_0000;
      run_xfer(su, ac, ps, pw);
      chk("to_psel", 64'(ps), 64'h02);
      chk("to_access_cycles", 64'(ac), 64'(TO));
      chk("to_resp", 64'({bus.rd_resp_valid, bus.rd_resp}), 64'b110);
      chk("to_data", 64'(bus.rd_resp_data), 64'h0);
      chk("to_idle_after", 64'({bus.psel, bus.penable}), 64'h0);

      // both directions pending: alternate starting with write
      do_reset();
      req_mode = 1;
      bus.wr_req_valid = 1; bus.wr_req_addr = 32'h0000_0100; bus.wr_req_data = 32'h5;
      bus.rd_req_valid = 1; bus.rd_req_addr = 32'h8000_0200;
      obs = '0; ng = 0;
      for (int i = 0; i < 60 && ng < 8; i++) begin
         cycle();
         if (bus.wr_req_ready) begin obs = {obs[6:0], 1'b1}; ng++; end
         else if (bus.rd_req_ready) begin obs = {obs[6:0], 1'b0}; ng++; end
      end
      chk("rr_order", 64'(obs), 64'b1010_1010);

      // unconsumed write response blocks writes, not reads
      do_reset();
      wrr_mode = 2;
      bus.wr_req_valid = 1; bus.wr_req_addr = 32'h0000_1000; bus.wr_req_data = 32'h1;
      run_xfer(su, ac, ps, pw);
      bus.wr_req_valid = 1; bus.wr_req_addr = 32'h6000_0000; bus.wr_req_data = 32'h2;
      bus.rd_req_valid = 1; bus.rd_req_addr = 32'hA000_0000;
      wg = 0; rg = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (bus.wr_req_ready) wg++;
         if (bus.rd_req_ready) rg++;
      end
      chk("blk_wr_grants", 64'(wg), 64'd0);
      chk("blk_rd_grants", 64'(rg), 64'd1);
      wrr_mode = 1;
      cycle();
      wrr_mode = 2;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         k++;
         if (bus.wr_req_ready) break;
      end
      chk("blk_release_delay", 64'(k), 64'd1);

      // asynchronous reset in the middle of ACCESS
      do_reset();
      sl_wait = 1000;
      bus.rd_req_valid = 1; bus.rd_req_addr = 32'hC000_0000;
      k = 0;
      for (int i = 0; i < 10 && !bus.penable; i++) cycle();
      chk("ar_in_access", 64'(bus.penable), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_psel", 64'(bus.psel), 64'h0);
      chk("ar_penable", 64'(bus.penable), 64'h0);
      chk("ar_paddr", 64'(bus.paddr), 64'h0);
      chk("ar_resp_valid", 64'({bus.wr_resp_valid, bus.rd_resp_valid}), 64'h0);
      clear_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) cycle();
      chk("ar_no_resp", 64'(bus.rd_resp_valid), 64'h0);

      // randomized traffic
      do_reset();
      req_mode = 0; wrr_mode = 0; rdr_mode = 0; sl_mode = 0;
      for (int i = 0; i < 4000 && n_err < 40; i++) begin
         if (i % 500 == 0) begin
            wrr_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            rdr_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
